// File: rtl/count_mon_pkg.sv
// Shared types and widths for the counter monitor: event codes, FSM states
// and the event payload carried through the event FIFO.
package count_mon_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned EVT_W   = 2;
  localparam int unsigned STATE_W = 2;

  typedef enum logic [EVT_W-1:0] {
    EV_WRAP    = 2'd0,
    EV_SAT     = 2'd1,
    EV_RESTART = 2'd2,
    EV_ERROR   = 2'd3
  } event_e;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_SAT   = 2'd2
  } state_e;

  typedef struct packed {
    event_e           code;
    logic [CNT_W-1:0] cnt;
  } event_t;

endpackage

// File: rtl/mon_event_fifo.sv
// Small synchronous FIFO of classified events. The head entry is presented
// directly from storage; a push into a full FIFO is accepted only if a pop
// frees a slot in the same cycle, otherwise it is dropped.
module mon_event_fifo
  import count_mon_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  event_t push_data,
  input  logic   pop,
  output logic   valid,
  output event_t head,
  output logic   dropped_c
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  event_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [FCNT_W-1:0] count;
  logic              full;
  logic              do_pop;
  logic              do_push;

  assign full      = (count == FCNT_W'(FIFO_DEPTH));
  assign do_pop    = pop && (count != '0);
  assign do_push   = push && (!full || do_pop);
  assign dropped_c = push && !do_push;

  assign valid = (count != '0);
  assign head  = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero until first push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + FCNT_W'(1);
        2'b01:   count <= count - FCNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/count_monitor.sv
// Watches an upstream 4-bit counter, classifies every sampled transition and
// queues WRAP/SAT/RESTART/ERROR events, with a wrap tally and sticky flags.
module count_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned SAT_VALUE  = 11,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WRAP_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cnt_in,
  input  logic              sat_en_in,
  input  logic              event_ready,
  output logic              event_valid,
  output logic [EVT_W-1:0]  event_code,
  output logic [CNT_W-1:0]  event_cnt,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              sat_flag,
  output logic              error_flag,
  output logic              overflow_flag
);

  localparam logic [CNT_W-1:0] SAT_CNT = CNT_W'(SAT_VALUE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] prev_q;
  logic             sat_hit_c;
  logic             push_c;
  event_e           code_c;
  logic             is_wrap_c;
  logic             is_err_c;
  event_t           push_data_c;
  event_t           head;
  logic             dropped_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Transition classifier; priority order matters where rules overlap.
  always_comb begin
    state_d   = state_q;
    push_c    = 1'b0;
    code_c    = EV_WRAP;
    is_wrap_c = 1'b0;
    is_err_c  = 1'b0;
    sat_hit_c = sat_en_in && (prev_q == SAT_CNT);
    case (state_q)
      ST_INIT: begin
        state_d = ST_TRACK;
      end
      ST_TRACK, ST_SAT: begin
        if (state_q == ST_SAT && cnt_in != prev_q) begin
          state_d = ST_TRACK;
        end
        if (cnt_in == '0 && (prev_q == CNT_MAX || sat_hit_c)) begin
          push_c    = 1'b1;
          code_c    = EV_WRAP;
          is_wrap_c = 1'b1;
        end else if (sat_hit_c && cnt_in == SAT_CNT && state_q == ST_TRACK) begin
          push_c  = 1'b1;
          code_c  = EV_SAT;
          state_d = ST_SAT;
        end else if (cnt_in == prev_q) begin
          push_c = 1'b0;
        end else if (cnt_in == prev_q + CNT_W'(1) && !sat_hit_c) begin
          push_c = 1'b0;
        end else if (cnt_in == '0) begin
          push_c = 1'b1;
          code_c = EV_RESTART;
        end else begin
          push_c   = 1'b1;
          code_c   = EV_ERROR;
          is_err_c = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  assign push_data_c.code = code_c;
  assign push_data_c.cnt  = cnt_in;

  // Tally and sticky status; wrap_count counts even when the event is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q        <= '0;
      wrap_count    <= '0;
      sat_flag      <= 1'b0;
      error_flag    <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      prev_q   <= cnt_in;
      sat_flag <= (state_d == ST_SAT);
      if (is_wrap_c && wrap_count != '1) begin
        wrap_count <= wrap_count + WRAP_W'(1);
      end
      if (is_err_c) begin
        error_flag <= 1'b1;
      end
      if (dropped_c) begin
        overflow_flag <= 1'b1;
      end
    end
  end

  mon_event_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_c),
    .push_data(push_data_c),
    .pop      (event_valid && event_ready),
    .valid    (event_valid),
    .head     (head),
    .dropped_c(dropped_c)
  );

  assign event_code = head.code;
  assign event_cnt  = head.cnt;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: a vector table for the main stream plus
// hand sequences for FIFO overflow, full pop+push and asynchronous reset.
module tb_count_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cnt_in;
  logic       sat_en_in;
  logic       event_ready;
  logic       event_valid;
  logic [1:0] event_code;
  logic [3:0] event_cnt;
  logic [7:0] wrap_count;
  logic       sat_flag;
  logic       error_flag;
  logic       overflow_flag;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] cnt;
    logic       sat_en;
    logic       ready;
    logic       exp_valid;
    logic [1:0] exp_code;
    logic [3:0] exp_ecnt;
    logic [7:0] exp_wrap;
    logic       exp_sat;
    logic       exp_err;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[$];

  count_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .cnt_in       (cnt_in),
    .sat_en_in    (sat_en_in),
    .event_ready  (event_ready),
    .event_valid  (event_valid),
    .event_code   (event_code),
    .event_cnt    (event_cnt),
    .wrap_count   (wrap_count),
    .sat_flag     (sat_flag),
    .error_flag   (error_flag),
    .overflow_flag(overflow_flag)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [3:0] c, input logic s, input logic r, input logic v,
                     input logic [1:0] code, input logic [3:0] ecnt, input logic [7:0] w,
                     input logic sf, input logic ef, input logic of);
    vec_t t;
    t.cnt = c; t.sat_en = s; t.ready = r; t.exp_valid = v; t.exp_code = code;
    t.exp_ecnt = ecnt; t.exp_wrap = w; t.exp_sat = sf; t.exp_err = ef; t.exp_ovf = of;
    vecs.push_back(t);
  endtask

  // Drive inputs, let one rising edge sample them, then settle 1ns past it.
  task automatic step(input logic [3:0] c, input logic s, input logic r);
    cnt_in = c; sat_en_in = s; event_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_all(input logic v, input logic [1:0] code,
      input logic [3:0] ecnt, input logic [7:0] w, input logic sf, input logic ef,
      input logic of, input logic mask);
    logic [1:0] mc;
    logic [3:0] me;
    mc = (mask && !v) ? 2'b0 : code;
    me = (mask && !v) ? 4'b0 : ecnt;
    return {14'b0, v, mc, me, w, sf, ef, of};
  endfunction

  function automatic logic [31:0] dut_all(input logic mask);
    return pack_all(event_valid, event_code, event_cnt, wrap_count, sat_flag,
                    error_flag, overflow_flag, mask);
  endfunction

  function automatic logic [31:0] dut_head();
    return {25'b0, event_valid, event_code, event_cnt};
  endfunction

  function automatic logic [31:0] head_of(input logic [1:0] code, input logic [3:0] ecnt);
    return {25'b0, 1'b1, code, ecnt};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic [1:0] q_code[4];
  logic [3:0] q_cnt[4];

  initial begin
    reset = 1'b1; cnt_in = '0; sat_en_in = 1'b0; event_ready = 1'b1;

    // Wrap at 15->0 without saturation.
    add(4'd0, 0, 1, 0, 2'd0, 4'd0, 8'd0, 0, 0, 0);
    for (int i = 1; i <= 15; i++) add(4'(i), 0, 1, 0, 2'd0, 4'd0, 8'd0, 0, 0, 0);
    add(4'd0, 0, 1, 1, 2'd0, 4'd0, 8'd1, 0, 0, 0);
    // Upstream reset while counting at 7.
    for (int i = 1; i <= 7; i++) add(4'(i), 0, 1, 0, 2'd0, 4'd0, 8'd1, 0, 0, 0);
    add(4'd0, 0, 1, 1, 2'd2, 4'd0, 8'd1, 0, 0, 0);
    // Saturate at 11 and hold.
    for (int i = 1; i <= 11; i++) add(4'(i), 1, 1, 0, 2'd0, 4'd0, 8'd1, 0, 0, 0);
    add(4'd11, 1, 1, 1, 2'd1, 4'd11, 8'd1, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(4'd11, 1, 1, 0, 2'd0, 4'd0, 8'd1, 1, 0, 0);
    // Wrap out of saturation, then an illegal jump.
    add(4'd0, 1, 1, 1, 2'd0, 4'd0, 8'd2, 0, 0, 0);
    add(4'd3, 1, 1, 1, 2'd3, 4'd3, 8'd2, 0, 1, 0);
    add(4'd4, 1, 1, 0, 2'd0, 4'd0, 8'd2, 0, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", dut_all(1'b0), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].cnt, vecs[i].sat_en, vecs[i].ready);
      check($sformatf("vec%0d", i), dut_all(1'b1),
            pack_all(vecs[i].exp_valid, vecs[i].exp_code, vecs[i].exp_ecnt, vecs[i].exp_wrap,
                     vecs[i].exp_sat, vecs[i].exp_err, vecs[i].exp_ovf, 1'b1));
    end

    // Six events into a 4-deep FIFO with the consumer stalled.
    step(4'd9, 0, 0);
    check("ovf_first_head", dut_head(), head_of(2'd3, 4'd9));
    step(4'd0, 0, 0);
    step(4'd5, 0, 0);
    step(4'd0, 0, 0);
    check("ovf_full_no_flag", {31'b0, overflow_flag}, 32'd0);
    step(4'd13, 0, 0);
    check("ovf_flag_set", {31'b0, overflow_flag}, 32'd1);
    step(4'd0, 0, 0);
    check("ovf_head_stable", dut_head(), head_of(2'd3, 4'd9));
    q_code = '{2'd3, 2'd2, 2'd3, 2'd2};
    q_cnt  = '{4'd9, 4'd0, 4'd5, 4'd0};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d", k), dut_head(), head_of(q_code[k], q_cnt[k]));
      step(4'd0, 0, 1);
    end
    check("drain_empty", {31'b0, event_valid}, 32'd0);

    // Full FIFO with simultaneous pop and push: nothing is lost.
    do_reset();
    step(4'd0, 0, 0);
    step(4'd9, 0, 0);
    step(4'd0, 0, 0);
    step(4'd5, 0, 0);
    step(4'd0, 0, 0);
    step(4'd12, 0, 1);
    check("full_poppush_no_ovf", {31'b0, overflow_flag}, 32'd0);
    q_code = '{2'd2, 2'd3, 2'd2, 2'd3};
    q_cnt  = '{4'd0, 4'd5, 4'd0, 4'd12};
    for (int k = 0; k < 4; k++) begin
      check($sformatf("pp_drain%0d", k), dut_head(), head_of(q_code[k], q_cnt[k]));
      step(4'd12, 0, 1);
    end
    check("pp_empty_no_ovf", {30'b0, event_valid, overflow_flag}, 32'd0);

    // Asynchronous reset with two events queued.
    step(4'd0, 0, 0);
    step(4'd7, 0, 0);
    check("pre_reset_queued", {30'b0, event_valid, error_flag}, 32'd3);
    #2 reset = 1'b1;
    #1 check("async_reset_zero", dut_all(1'b0), 32'd0);
    #1 reset = 1'b0;
    step(4'd5, 0, 1);
    check("post_reset_first", dut_all(1'b0), 32'd0);
    step(4'd5, 0, 1);
    check("post_reset_hold", dut_all(1'b1), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
